irq_pending_ctrl: RTL and testbench
===================================

# irq_pending_ctrl

Four-line interrupt/request capture stage that feeds the team's 4-to-2 priority encoder `encoder`. It edge- or level-captures requests into a pending register, masks them and priority-encodes them (line 3 highest). It then presents one winning index at a time to a downstream consumer over a valid/ack handshake. An acknowledged line is cleared; all other lines stay pending and are presented afterwards.

## Interface
- `EDGE`, default 1: 1 = capture on rising edge of `req[i]`; 0 = capture while `req[i]` is high (level).
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  4  request lines, already synchronous to `clk`.
- `mask`  in  4  1 = line blocked from presentation; capture is unaffected.
- `irq_ack`  in  1  consumer accepts the presented index.
- `clr_ovf`  in  1  clears all `ovf` bits.
- `irq_valid`  out  1  an index is presented.
- `irq_id`  out  2  presented index, 3 = highest priority.
- `pending`  out  4  registered pending vector.
- `ovf`  out  4  sticky: a new event arrived on a line already pending.

## Operation
- Reset state: `pending`=0, `ovf`=0, `irq_valid`=0, `irq_id`=0, FSM=IDLE.
- During reset, `req_d` loads `req`, so lines held high through reset produce no edge.
- `set_vec` = `EDGE` ? (`req` & ~`req_d`) : `req`.
- `clr_vec` = one-hot(`irq_id`) when `irq_valid` & `irq_ack`, else 0.
- Next `pending` = (`pending` & ~`clr_vec`) | `set_vec`.
- Set wins over clear on the same line in the same cycle: the event is retained and re-presented later.
- `ovf[i]` sets when `set_vec[i]` & `pending[i]` & ~`clr_vec[i]`.
- `clr_ovf` clears `ovf`. A set in the same cycle wins.
- `ovf` is never set in level mode; level mode holds `pending` high while `req` is high.
- FSM has two states.
  - IDLE: when `masked` = `pending` & ~`mask` is nonzero, register `irq_id` from `encoder(Y=masked)` and set `irq_valid`=1, then go to PRESENT. Otherwise stay in IDLE.
  - PRESENT: hold `irq_id` and `irq_valid` stable. On `irq_ack`, clear `irq_valid`, clear the pending bit and return to IDLE.
- The presented index is never withdrawn in PRESENT, even if `mask` or a higher-priority request changes.
- `irq_ack` is ignored in IDLE.

## Timing
- Capture latency: `req` first sampled high at edge E0 → `pending` bit set after E0 → `irq_valid`=1 and `irq_id` valid after E1.
- Ack at edge Ek → `irq_valid`=0 after Ek.
  - The next presentation appears no earlier than after Ek+1.
  - This gives a minimum one-cycle gap of `irq_valid` low between grants.
- Back-to-back throughput: one grant per 2 cycles.
- Simultaneous set on several lines: all are captured in one cycle and presented in descending index order.
- Reset asserted mid-PRESENT: after that edge all outputs are at reset values; any pending work is lost.

## Structure
- Package `irq_pkg`:
  - `N_REQ`=4, `ID_W`=2.
  - State enum `irq_state_t` {IDLE, PRESENT}.
- Sub-module: the existing `encoder` (`Y[3:0]` → `A[1:0]`, Y[3] highest), instantiated once on `masked`.
- All registers live in the top: `req_d`, `pending`, `ovf`, state, `irq_id`, `irq_valid`.

## Test plan
- EDGE=1, reset with `req`=4'b0010 held → no capture; then pulse `req[2]` → `irq_valid`=1, `irq_id`=2 two edges after sampling; ack → `pending`=4'b0000.
- `req`=4'b1010 in one cycle, `mask`=0 → presents id 3, ack, one idle cycle, presents id 1, ack, then `irq_valid` stays 0.
- `pending[0]` set, `mask`=4'b0001 → `irq_valid` stays 0. Clear the mask → id 0 presented. Set `mask` during PRESENT → id 0 held until ack.
- New `req[1]` edge while `pending[1]`=1 and not being acked → `ovf`=4'b0010. Edge in the ack cycle of id 1 → no `ovf`, `pending[1]` stays 1, re-presented. `clr_ovf` → `ovf`=0.
- EDGE=0, `req[3]` held high → id 3 re-presented after every ack (valid low one cycle between). Drop `req[3]` before ack → cleared after ack.
- Assert `rst` for one cycle while presenting id 2 with `pending`=4'b0110 → next cycle all outputs 0, FSM IDLE.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and constants for the four-line interrupt pending controller.
package irq_pkg;
  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  typedef enum logic {IDLE, PRESENT} irq_state_t;

  function automatic logic [N_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/irq_pending_ctrl_encoder.sv
// 4-to-2 priority encoder, Y[3] highest; combinational, A=0 when Y is empty.
module encoder (
  input  logic [3:0] Y,
  output logic [1:0] A
);
  always_comb begin
    A = 2'd0;
    if (Y[3])      A = 2'd3;
    else if (Y[2]) A = 2'd2;
    else if (Y[1]) A = 2'd1;
  end
endmodule

// File: rtl/irq_pending_ctrl.sv
// Captures 4 request lines into a pending vector and presents the highest unmasked one.
// Latency: req to irq_valid 2 edges; a presented id is held until irq_ack, one grant per 2 cycles.
module irq_pending_ctrl
  import irq_pkg::*;
#(
  parameter logic EDGE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic             irq_ack,
  input  logic             clr_ovf,
  output logic             irq_valid,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_REQ-1:0] pending,
  output logic [N_REQ-1:0] ovf
);
  logic [N_REQ-1:0] req_d_q, req_d_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [N_REQ-1:0] ovf_q, ovf_d;
  logic [ID_W-1:0]  irq_id_q, irq_id_d;
  logic             irq_valid_q, irq_valid_d;
  irq_state_t       state_q, state_d;

  logic [N_REQ-1:0] set_vec, clr_vec, masked;
  logic [ID_W-1:0]  enc_id;

  assign masked = pending_q & ~mask;

  encoder u_encoder (
    .Y (masked),
    .A (enc_id)
  );

  // Set is OR'd in after the clear, so an event landing on the acked line survives.
  always_comb begin
    req_d_d   = req;
    set_vec   = EDGE ? (req & ~req_d_q) : req;
    clr_vec   = (irq_valid_q && irq_ack) ? id_onehot(irq_id_q) : '0;
    pending_d = (pending_q & ~clr_vec) | set_vec;
    ovf_d     = (clr_ovf ? '0 : ovf_q) | (EDGE ? (set_vec & pending_q & ~clr_vec) : '0);
  end

  always_comb begin
    state_d     = state_q;
    irq_id_d    = irq_id_q;
    irq_valid_d = irq_valid_q;
    case (state_q)
      IDLE: begin
        if (|masked) begin
          irq_id_d    = enc_id;
          irq_valid_d = 1'b1;
          state_d     = PRESENT;
        end
      end
      PRESENT: begin
        if (irq_ack) begin
          irq_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // req_d tracks req even in reset so lines held high through reset give no edge.
  always_ff @(posedge clk) begin
    req_d_q <= req_d_d;
    if (rst) begin
      pending_q   <= '0;
      ovf_q       <= '0;
      irq_id_q    <= '0;
      irq_valid_q <= 1'b0;
      state_q     <= IDLE;
    end else begin
      pending_q   <= pending_d;
      ovf_q       <= ovf_d;
      irq_id_q    <= irq_id_d;
      irq_valid_q <= irq_valid_d;
      state_q     <= state_d;
    end
  end

  assign irq_valid = irq_valid_q;
  assign irq_id    = irq_id_q;
  assign pending   = pending_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Bench for irq_pending_ctrl: edge-mode and level-mode instances share stimulus.
module tb_irq_pending_ctrl;
  logic       clk = 1'b0;
  logic       rst, irq_ack, clr_ovf;
  logic [3:0] req, mask;

  logic       vld_e, vld_l;
  logic [1:0] id_e, id_l;
  logic [3:0] pend_e, pend_l, ovf_e, ovf_l;

  int errors = 0;
  int checks = 0;

  // reference state, index 0 = edge mode, 1 = level mode
  logic [3:0] m_pend [2];
  logic [3:0] m_ovf  [2];
  logic       m_vld  [2];
  int         m_id   [2];
  logic [3:0] m_prev;

  always #5 clk = ~clk;

  irq_pending_ctrl #(.EDGE(1'b1)) dut_e (
    .clk(clk), .rst(rst), .req(req), .mask(mask), .irq_ack(irq_ack), .clr_ovf(clr_ovf),
    .irq_valid(vld_e), .irq_id(id_e), .pending(pend_e), .ovf(ovf_e)
  );

  irq_pending_ctrl #(.EDGE(1'b0)) dut_l (
    .clk(clk), .rst(rst), .req(req), .mask(mask), .irq_ack(irq_ack), .clr_ovf(clr_ovf),
    .irq_valid(vld_l), .irq_id(id_l), .pending(pend_l), .ovf(ovf_l)
  );

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: events per line, the acked line drops, events always land;
  // an idle presenter picks the highest pending unmasked line.
  task automatic model_tick();
    for (int e = 0; e < 2; e++) begin
      logic       edge_m, ev, acked;
      logic [3:0] np, no;
      int         ack_line;
      edge_m = (e == 0);
      np = '0;
      if (rst) begin
        m_pend[e] = '0; m_ovf[e] = '0; m_vld[e] = 1'b0; m_id[e] = 0;
      end else begin
        ack_line = (m_vld[e] && irq_ack) ? m_id[e] : -1;
        no = clr_ovf ? 4'b0000 : m_ovf[e];
        for (int i = 0; i < 4; i++) begin
          ev    = edge_m ? (req[i] && !m_prev[i]) : req[i];
          acked = (i == ack_line);
          np[i] = (m_pend[e][i] && !acked) || ev;
          if (edge_m && ev && m_pend[e][i] && !acked) no[i] = 1'b1;
        end
        if (!m_vld[e]) begin
          for (int i = 0; i < 4; i++)
            if (m_pend[e][i] && !mask[i]) begin
              m_vld[e] = 1'b1;
              m_id[e]  = i;
            end
        end else if (irq_ack) begin
          m_vld[e] = 1'b0;
        end
        m_pend[e] = np;
        m_ovf[e]  = no;
      end
    end
    m_prev = req;
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
    check4("edge valid",   {3'b0, vld_e}, {3'b0, m_vld[0]});
    check4("edge id",      {2'b0, id_e},  4'(m_id[0]));
    check4("edge pending", pend_e,        m_pend[0]);
    check4("edge ovf",     ovf_e,         m_ovf[0]);
    check4("lvl valid",    {3'b0, vld_l}, {3'b0, m_vld[1]});
    check4("lvl id",       {2'b0, id_l},  4'(m_id[1]));
    check4("lvl pending",  pend_l,        m_pend[1]);
    check4("lvl ovf",      ovf_l,         m_ovf[1]);
  endtask

  initial begin
    m_pend[0] = 'x; m_pend[1] = 'x; m_ovf[0] = 'x; m_ovf[1] = 'x;
    m_vld[0] = 1'bx; m_vld[1] = 1'bx; m_id[0] = 0; m_id[1] = 0; m_prev = '0;
    rst = 1'b1; req = 4'b0010; mask = 4'b0000; irq_ack = 1'b0; clr_ovf = 1'b0;

    // reset with req[1] held high: no edge afterwards
    step(); step();
    check4("reset pending", pend_e, 4'b0000);
    check4("reset valid", {3'b0, vld_e}, 4'b0000);
    rst = 1'b0;
    step(); step();
    check4("held through reset", pend_e, 4'b0000);

    // single edge on line 2
    req = 4'b0110; step();
    check4("capture line 2", pend_e, 4'b0100);
    step();
    check4("present 2 valid", {3'b0, vld_e}, 4'b0001);
    check4("present 2 id", {2'b0, id_e}, 4'd2);
    irq_ack = 1'b1; step();
    check4("ack 2 valid", {3'b0, vld_e}, 4'b0000);
    check4("ack 2 pending", pend_e, 4'b0000);
    irq_ack = 1'b0; req = 4'b0000; step();

    // simultaneous 3 and 1
    req = 4'b1010; step();
    req = 4'b0000; step();
    check4("multi first id", {2'b0, id_e}, 4'd3);
    irq_ack = 1'b1; step();
    check4("gap after ack", {3'b0, vld_e}, 4'b0000);
    irq_ack = 1'b0; step();
    check4("multi second id", {2'b0, id_e}, 4'd1);
    check4("multi second valid", {3'b0, vld_e}, 4'b0001);
    irq_ack = 1'b1; step();
    irq_ack = 1'b0; step(); step();
    check4("drained valid", {3'b0, vld_e}, 4'b0000);

    // masking
    mask = 4'b0001; req = 4'b0001; step();
    req = 4'b0000; step(); step();
    check4("masked no valid", {3'b0, vld_e}, 4'b0000);
    mask = 4'b0000; step();
    check4("unmasked id0", {3'b0, vld_e}, 4'b0001);
    mask = 4'b1111; step(); step();
    check4("mask in present held", {3'b0, vld_e}, 4'b0001);
    irq_ack = 1'b1; step();
    irq_ack = 1'b0; mask = 4'b0000; step();

    // overflow and set-beats-clear
    mask = 4'b1111; req = 4'b0010; step();
    req = 4'b0000; step();
    req = 4'b0010; step();
    check4("ovf set", ovf_e, 4'b0010);
    req = 4'b0000; mask = 4'b0000; step(); step();
    req = 4'b0010; irq_ack = 1'b1; step();
    check4("set beats clear pending", pend_e, 4'b0010);
    check4("no ovf on ack cycle", ovf_e, 4'b0010);
    irq_ack = 1'b0; req = 4'b0000; step();
    check4("re-present id1", {2'b0, id_e}, 4'd1);
    clr_ovf = 1'b1; step();
    check4("clr ovf", ovf_e, 4'b0000);
    clr_ovf = 1'b0; irq_ack = 1'b1; step();
    irq_ack = 1'b0; step();

    // level: req[3] held high, acks re-present, then drop
    req = 4'b1000;
    for (int k = 0; k < 10; k++) begin
      irq_ack = k[0]; step();
    end
    req = 4'b0000; irq_ack = 1'b0; step();
    irq_ack = 1'b1; step(); step();
    irq_ack = 1'b0; step(); step();

    // reset mid-present
    req = 4'b0110; step();
    req = 4'b0000; step();
    check4("pre-reset id", {2'b0, id_e}, 4'd2);
    check4("pre-reset pending", pend_e, 4'b0110);
    rst = 1'b1; step();
    check4("mid reset valid", {3'b0, vld_e}, 4'b0000);
    check4("mid reset pending", pend_e, 4'b0000);
    rst = 1'b0; step();

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      req     = 4'($urandom);
      mask    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      irq_ack = 1'($urandom_range(0, 1));
      clr_ovf = ($urandom_range(0, 15) == 0);
      rst     = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
